// File: rtl/sigmoid_reg_reader.sv
// Burst read sequencer for the sigmoid register bank: walks base_addr..base_addr+count-1
// and streams each entry out over valid/ready. Build option: SIGMOID_READER_WRAP_EN.
module sigmoid_reg_reader #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  // Handshake: a word transfers on a rising edge where out_valid && out_ready;
  // out_valid is held with stable out_data until that edge.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH:0]   MAX_COUNT = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    done_q, done_d;
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic                    bank_end;

`ifdef SIGMOID_READER_WRAP_EN
  // Address increment wraps modulo 2**ADDR_WIDTH, so the bank end never stops a burst.
  assign bank_end = 1'b0;
`else
  assign bank_end = (rd_addr_q == LAST_ADDR);
`endif

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rd_addr_d   = base_addr;
          remaining_d = (count > MAX_COUNT) ? MAX_COUNT : count;
          state_d     = (count == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        out_data_d = rd_data;
        state_d    = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (ADDR_WIDTH+1)'(1) || bank_end) begin
            state_d = DONE;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Flag outputs are registered decodes of the next state.
    out_valid_d = (state_d == PRESENT);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule
